blit_cmd_fifo: RTL and testbench
================================

Name: blit_cmd_fifo

Overview:
- Command queue between the hardware-register block and the blitter engine.
- Captures each 128-bit blitter command (written on the BLIT_CMD strobe) and presents commands to the blitter in order over a valid/ready handshake.
- Reports free capacity back for the BLIT_CMD read value, and flags commands dropped on overflow.

Parameters:
- DEPTH, 16: total command capacity in entries, including the output register; legal range 2..255.
- CMD_W, 128: command width in bits.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_in  in  CMD_W  command word; sampled when cmd_in_valid=1
- cmd_in_valid  in  1  single-cycle push strobe
- slots_free  out  8  DEPTH minus occupancy; registered
- overflow  out  1  sticky: a push was dropped
- overflow_clear  in  1  clears overflow
- cmd_out  out  CMD_W  head command to blitter
- cmd_out_valid  out  1  cmd_out holds a valid command
- cmd_out_ready  in  1  blitter accepts head this cycle

Behaviour:
- Interface: one clock, clock; reset is asynchronous, active-high, named reset.
- Reset values: slots_free=DEPTH, overflow=0, cmd_out_valid=0, cmd_out=0, all pointers=0.
- Storage:
  - DEPTH-1 entry RAM array plus one output register (first-word-fall-through).
  - Write and read pointers are log2 wide with an extra wrap bit.
  - Pointers wrap modulo DEPTH-1.
- pop: cmd_out_valid & cmd_out_ready.
- push accepted: cmd_in_valid & (occupancy<DEPTH | pop).
- Full with simultaneous push and pop: the push is accepted and occupancy stays at DEPTH.
- Push into an empty FIFO, or into a FIFO whose only entry is being popped:
  - Data goes directly to the output register.
  - cmd_out_valid=1 on the following cycle (1-cycle latency).
- Otherwise a push writes the RAM at the write pointer. The RAM is a synchronous-write array.
- On pop with RAM non-empty, the output register loads the RAM head in the same edge. Back-to-back pops sustain 1 command/cycle.
- cmd_out must hold stable while cmd_out_valid=1 and cmd_out_ready=0.
- Occupancy: updated each edge by +push_accepted -pop. slots_free = DEPTH - occupancy, visible the cycle after the event.
- Overflow:
  - Set on an edge where cmd_in_valid=1 and the push is not accepted.
  - The dropped command is discarded; no state other than overflow changes.
  - Cleared by overflow_clear. If set and clear happen in the same cycle, set wins.
- cmd_out_ready while cmd_out_valid=0 is ignored.
- Reset mid-operation: all queued commands are discarded immediately (async). The first push after reset release behaves as the empty case.
- Ordering: strict FIFO; no reordering or merging.

Optional Feature:
- Macro: BLIT_CMD_FIFO_STATS_EN.
- With the macro defined:
  - Adds output high_water [7:0]: maximum occupancy since reset, reset value 0.
  - Adds output drop_count [15:0]: count of dropped pushes, saturating at 16'hFFFF, reset value 0.
  - Both counters clear on overflow_clear (high_water clears to the current occupancy).
- Without the macro: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package blit_pkg holds:
  - typedef blit_cmd_t: packed struct of CMD_W bits, fields op[31:0], arg1[31:0], arg2[31:0], color[31:0], with op in the LSBs.
  - localparam BLIT_FIFO_DEPTH_DEFAULT=16.
- One natural sub-module: blit_cmd_ram, a DEPTH-1 x CMD_W simple dual-port array with synchronous write and async read (or a registered read with an adjusted FWFT path), inferable as block RAM.
- Pointer and occupancy logic stay in the top module.

Test Plan:
- Reset, then a single push of cmd_in=128'h...0001 with ready=0:
  - cmd_out_valid rises 1 cycle later.
  - slots_free goes 16→15.
  - cmd_out is held for 10 cycles.
- Push 16 commands with ready=0, then push a 17th:
  - slots_free=0.
  - overflow=1.
  - The 17th command never appears on cmd_out.
  - Drain with ready=1 yields commands 1..16 in order.
- Full FIFO, simultaneous push and pop in one cycle:
  - slots_free stays 0 and overflow stays 0.
  - The new command emerges last.
- Continuous push of 40 commands with ready=1 throughout:
  - One pop per cycle after the first-cycle latency.
  - Order is preserved across pointer wrap (wraps at 15).
  - slots_free never drops below 15.
- Assert reset while 5 entries are queued:
  - cmd_out_valid=0, slots_free=16, overflow=0 in the same cycle.
  - A subsequent push appears after 1 cycle.
- overflow set, then overflow_clear asserted alone → overflow=0 next cycle. With the feature on, drop_count=1 before the clear and 0 after.

Source files
------------

// File: rtl/blit_pkg.sv
// Shared types and constants for the blitter command path.
package blit_pkg;

    localparam int unsigned BLIT_FIFO_DEPTH_DEFAULT = 16;
    localparam int unsigned BLIT_CMD_W              = 128;

    // One blitter command; op occupies the least significant word.
    typedef struct packed {
        logic [31:0] color;
        logic [31:0] arg2;
        logic [31:0] arg1;
        logic [31:0] op;
    } blit_cmd_t;

    // Index width for an array of the given size (never below one bit).
    function automatic int unsigned blit_ptr_w(input int unsigned entries);
        return (entries > 1) ? $clog2(entries) : 1;
    endfunction

endpackage

// File: rtl/blit_cmd_ram.sv
// Simple dual-port command storage: synchronous write, asynchronous read.
module blit_cmd_ram #(
    parameter int unsigned ENTRIES = 15,
    parameter int unsigned WIDTH   = 128,
    parameter int unsigned AW      = 4
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [ENTRIES];

    // Write port: store the incoming command at the write address.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/blit_cmd_fifo.sv
// Blitter command queue: first-word-fall-through FIFO built from a
// DEPTH-1 entry RAM plus an output register, with free-slot reporting
// and a sticky overflow flag.
// Optional statistics (high_water, drop_count) with BLIT_CMD_FIFO_STATS_EN.
module blit_cmd_fifo
    import blit_pkg::*;
#(
    parameter int unsigned DEPTH = BLIT_FIFO_DEPTH_DEFAULT,
    parameter int unsigned CMD_W = BLIT_CMD_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [CMD_W-1:0] cmd_in,
    input  logic             cmd_in_valid,
    output logic [7:0]       slots_free,
    output logic             overflow,
    input  logic             overflow_clear,
    output logic [CMD_W-1:0] cmd_out,
    output logic             cmd_out_valid,
    input  logic             cmd_out_ready
`ifdef BLIT_CMD_FIFO_STATS_EN
    ,
    output logic [7:0]       high_water,
    output logic [15:0]      drop_count
`endif
);

    localparam int unsigned RAM_N   = DEPTH - 1;
    localparam int unsigned AW      = blit_ptr_w(RAM_N);
    localparam logic [7:0]  DEPTH_B = 8'(DEPTH);

    // Advance a RAM pointer; the index wraps at RAM_N and flips the wrap bit.
    function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
        if (p[AW-1:0] == AW'(RAM_N - 1)) begin
            return {~p[AW], {AW{1'b0}}};
        end
        return {p[AW], p[AW-1:0] + AW'(1)};
    endfunction

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [7:0]       occ_q, occ_d;
    logic [7:0]       slots_q, slots_d;
    logic             ovf_q, ovf_d;
    logic [CMD_W-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;

    logic             pop, push_ok, drop, to_out, ram_we, ram_empty;
    logic [CMD_W-1:0] ram_rdata;

    blit_cmd_ram #(
        .ENTRIES (RAM_N),
        .WIDTH   (CMD_W),
        .AW      (AW)
    ) u_ram (
        .clk_i   (clock),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (cmd_in),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    // Handshake decode and next-state for pointers, output register, occupancy.
    always_comb begin
        pop       = out_valid_q & cmd_out_ready;
        ram_empty = (wr_ptr_q == rd_ptr_q);
        push_ok   = cmd_in_valid & ((occ_q < DEPTH_B) | pop);
        drop      = cmd_in_valid & ~push_ok;
        // Bypass the RAM when the output register is (or is becoming) empty
        // and nothing is queued behind it, giving one-cycle latency.
        to_out    = push_ok & (~out_valid_q | (pop & ram_empty));
        ram_we    = push_ok & ~to_out;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;

        if (pop) begin
            if (!ram_empty) begin
                out_d    = ram_rdata;
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else if (to_out) begin
                out_d = cmd_in;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (to_out) begin
            out_d       = cmd_in;
            out_valid_d = 1'b1;
        end

        if (ram_we) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end

        unique case ({push_ok, pop})
            2'b10:   occ_d = occ_q + 8'd1;
            2'b01:   occ_d = occ_q - 8'd1;
            default: occ_d = occ_q;
        endcase

        slots_d = DEPTH_B - occ_d;
        ovf_d   = drop | (ovf_q & ~overflow_clear);
    end

    // Queue state registers; reset discards every queued command.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            slots_q     <= DEPTH_B;
            ovf_q       <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            slots_q     <= slots_d;
            ovf_q       <= ovf_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign slots_free    = slots_q;
    assign overflow      = ovf_q;
    assign cmd_out       = out_q;
    assign cmd_out_valid = out_valid_q;

`ifdef BLIT_CMD_FIFO_STATS_EN
    logic [7:0]  hw_q, hw_d;
    logic [15:0] drops_q, drops_d;
    logic [15:0] drops_base;

    // Statistics next-state: peak occupancy and saturating drop counter.
    always_comb begin
        if (overflow_clear) begin
            hw_d = occ_d;
        end else begin
            hw_d = (occ_d > hw_q) ? occ_d : hw_q;
        end
        drops_base = overflow_clear ? '0 : drops_q;
        drops_d    = drops_base;
        if (drop && (drops_base != '1)) begin
            drops_d = drops_base + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hw_q    <= '0;
            drops_q <= '0;
        end else begin
            hw_q    <= hw_d;
            drops_q <= drops_d;
        end
    end

    assign high_water = hw_q;
    assign drop_count = drops_q;
`endif

endmodule

// File: tb/tb_blit_cmd_fifo.sv
// Directed self-checking bench for blit_cmd_fifo (DEPTH=16, CMD_W=128).
module tb_blit_cmd_fifo;
    import blit_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CMD_W = 128;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [CMD_W-1:0] cmd_in = '0;
    logic             cmd_in_valid = 1'b0;
    logic [7:0]       slots_free;
    logic             overflow;
    logic             overflow_clear = 1'b0;
    logic [CMD_W-1:0] cmd_out;
    logic             cmd_out_valid;
    logic             cmd_out_ready = 1'b0;
`ifdef BLIT_CMD_FIFO_STATS_EN
    logic [7:0]       high_water;
    logic [15:0]      drop_count;
`endif

    int unsigned passed = 0;
    int unsigned total  = 0;

    blit_cmd_fifo #(
        .DEPTH (DEPTH),
        .CMD_W (CMD_W)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .cmd_in         (cmd_in),
        .cmd_in_valid   (cmd_in_valid),
        .slots_free     (slots_free),
        .overflow       (overflow),
        .overflow_clear (overflow_clear),
        .cmd_out        (cmd_out),
        .cmd_out_valid  (cmd_out_valid),
        .cmd_out_ready  (cmd_out_ready)
`ifdef BLIT_CMD_FIFO_STATS_EN
        ,
        .high_water     (high_water),
        .drop_count     (drop_count)
`endif
    );

    always #5 clock = ~clock;

    // Distinct, recognisable command for sequence number n.
    function automatic logic [CMD_W-1:0] mk(input int unsigned n);
        blit_cmd_t c;
        c.op    = n;
        c.arg1  = n * 3;
        c.arg2  = 32'hA5A5_0000 | n;
        c.color = ~n;
        return c;
    endfunction

    task automatic check(input string tag, input logic [CMD_W-1:0] obs,
                         input logic [CMD_W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached (%0d/%0d checks passed)", passed, total);
        $fatal(1);
    end

    initial begin
        // Reset state
        reset = 1'b1;
        tick();
        tick();
        check("rst_valid", cmd_out_valid, 0);
        check("rst_slots", slots_free, 16);
        check("rst_ovf", overflow, 0);
        check("rst_data", cmd_out, 0);
`ifdef BLIT_CMD_FIFO_STATS_EN
        check("rst_hw", high_water, 0);
        check("rst_drops", drop_count, 0);
`endif
        reset = 1'b0;
        tick();

        // Single push, held for 10 cycles with ready low
        cmd_in = mk(1);
        cmd_in_valid = 1'b1;
        tick();
        cmd_in_valid = 1'b0;
        check("push1_valid", cmd_out_valid, 1);
        check("push1_slots", slots_free, 15);
        check("push1_data", cmd_out, mk(1));
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_valid", cmd_out_valid, 1);
            check("hold_data", cmd_out, mk(1));
            check("hold_slots", slots_free, 15);
        end

        // Fill to 16 entries
        for (int unsigned n = 2; n <= 16; n++) begin
            cmd_in = mk(n);
            cmd_in_valid = 1'b1;
            tick();
        end
        cmd_in_valid = 1'b0;
        check("full_slots", slots_free, 0);
        check("full_ovf", overflow, 0);
        check("full_head", cmd_out, mk(1));

        // 17th push is dropped
        cmd_in = mk(17);
        cmd_in_valid = 1'b1;
        tick();
        cmd_in_valid = 1'b0;
        check("drop_ovf", overflow, 1);
        check("drop_slots", slots_free, 0);
        check("drop_head", cmd_out, mk(1));
`ifdef BLIT_CMD_FIFO_STATS_EN
        check("drop_cnt", drop_count, 1);
        check("drop_hw", high_water, 16);
`endif

        // Clear alone
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        check("clr_ovf", overflow, 0);
`ifdef BLIT_CMD_FIFO_STATS_EN
        check("clr_cnt", drop_count, 0);
        check("clr_hw", high_water, 16);
`endif

        // Drop and clear in the same cycle: set wins
        cmd_in = mk(18);
        cmd_in_valid = 1'b1;
        overflow_clear = 1'b1;
        tick();
        cmd_in_valid = 1'b0;
        check("setwin_ovf", overflow, 1);
        check("setwin_slots", slots_free, 0);
`ifdef BLIT_CMD_FIFO_STATS_EN
        check("setwin_cnt", drop_count, 1);
`endif
        tick();
        overflow_clear = 1'b0;
        check("clr2_ovf", overflow, 0);

        // Full FIFO, simultaneous push and pop
        cmd_in = mk(100);
        cmd_in_valid = 1'b1;
        cmd_out_ready = 1'b1;
        tick();
        cmd_in_valid = 1'b0;
        check("pp_slots", slots_free, 0);
        check("pp_ovf", overflow, 0);
        check("pp_head", cmd_out, mk(2));

        // Drain: 2..16 then 100
        for (int unsigned n = 2; n <= 17; n++) begin
            check("drain_valid", cmd_out_valid, 1);
            check("drain_data", cmd_out, (n == 17) ? mk(100) : mk(n));
            tick();
        end
        check("drained_valid", cmd_out_valid, 0);
        check("drained_slots", slots_free, 16);

        // Continuous push with ready high: one pop per cycle
        for (int unsigned k = 0; k < 40; k++) begin
            cmd_in = mk(200 + k);
            cmd_in_valid = 1'b1;
            tick();
            check("stream_valid", cmd_out_valid, 1);
            check("stream_data", cmd_out, mk(200 + k));
            check("stream_slots", slots_free, 15);
        end
        cmd_in_valid = 1'b0;
        tick();
        check("stream_end_valid", cmd_out_valid, 0);
        check("stream_end_slots", slots_free, 16);

        // Streaming through the RAM with three entries resident (pointer wrap)
        cmd_out_ready = 1'b0;
        for (int unsigned j = 0; j < 3; j++) begin
            cmd_in = mk(300 + j);
            cmd_in_valid = 1'b1;
            tick();
        end
        check("wrap_pre_slots", slots_free, 13);
        check("wrap_pre_head", cmd_out, mk(300));
        cmd_out_ready = 1'b1;
        for (int unsigned j = 3; j < 43; j++) begin
            cmd_in = mk(300 + j);
            cmd_in_valid = 1'b1;
            tick();
            check("wrap_data", cmd_out, mk(300 + j - 2));
            check("wrap_slots", slots_free, 13);
        end
        cmd_in_valid = 1'b0;
        tick();
        check("wrap_tail1", cmd_out, mk(341));
        tick();
        check("wrap_tail2", cmd_out, mk(342));
        check("wrap_tail2_valid", cmd_out_valid, 1);
        tick();
        check("wrap_empty", cmd_out_valid, 0);
        check("wrap_empty_slots", slots_free, 16);

        // Reset with five entries queued
        cmd_out_ready = 1'b0;
        for (int unsigned j = 0; j < 5; j++) begin
            cmd_in = mk(400 + j);
            cmd_in_valid = 1'b1;
            tick();
        end
        cmd_in_valid = 1'b0;
        check("q5_slots", slots_free, 11);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", cmd_out_valid, 0);
        check("arst_slots", slots_free, 16);
        check("arst_ovf", overflow, 0);
        check("arst_data", cmd_out, 0);
        tick();
        reset = 1'b0;
        tick();
        cmd_in = mk(500);
        cmd_in_valid = 1'b1;
        tick();
        cmd_in_valid = 1'b0;
        check("post_rst_valid", cmd_out_valid, 1);
        check("post_rst_data", cmd_out, mk(500));
        check("post_rst_slots", slots_free, 15);
        cmd_out_ready = 1'b1;
        tick();
        check("post_rst_pop", cmd_out_valid, 0);
        check("post_rst_slots2", slots_free, 16);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
